// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, sync polarity encoding
// and small decode helpers used by the VGA timing generator.
package vga_timing_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Coordinate counter width and default pixel clock divider
  localparam int VGA_CNT_W   = 10;
  localparam int VGA_CLK_DIV = 1;

  // Sync polarity: the value is the level driven while the sync is asserted
  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam logic VGA_SYNC_POL = SYNC_ACTIVE_LOW;

  // True when lo <= val <= hi
  function automatic logic in_window(input int unsigned val,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // Pin level for a sync that is (or is not) inside its window
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_pix_en_div.sv
// vga_pix_en_div: divides i_clk into a registered one-cycle pixel strobe.
// The divider counts only while i_enable is high, so freezing the raster
// also freezes the phase of the strobe.
module vga_pix_en_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_pix_en_div: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             wrap_s;
  logic             pix_en_r;

  // Next divider count and terminal-count detect, gated by i_enable
  always_comb begin
    div_nxt_s = div_cnt_r;
    wrap_s    = 1'b0;
    if (i_enable) begin
      wrap_s = (div_cnt_r == DIV_LAST);
      if (div_cnt_r == DIV_LAST) begin
        div_nxt_s = '0;
      end else begin
        div_nxt_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_nxt_s = div_cnt_r;
      wrap_s    = 1'b0;
    end
  end

  // Divider state and registered strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt_r <= '0;
      pix_en_r  <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      pix_en_r  <= wrap_s;
    end
  end

  assign o_pix_en = pix_en_r;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters plus sync / active / strobe decode for the
// VGA test-pattern pipeline. Every output is registered from the post-advance
// counter values, so syncs, active and strobes always describe o_col/o_row.
// A low i_enable freezes the raster on the same edge it is seen.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter logic SYNC_POL = VGA_SYNC_POL,
  parameter int   CNT_W    = VGA_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  output logic             o_pix_en,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_line_start,
  output logic             o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;

  if (H_TOTAL > (1 << CNT_W)) begin : g_chk_h
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_chk_v
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic             pix_en_s;
  logic             advance_s;
  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic [CNT_W-1:0] h_nxt_s;
  logic [CNT_W-1:0] v_nxt_s;
  logic             active_nxt_s;
  logic             hsync_nxt_s;
  logic             vsync_nxt_s;
  logic             line_start_nxt_s;
  logic             frame_start_nxt_s;
  logic             active_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             line_start_r;
  logic             frame_start_r;

  vga_pix_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_en_div (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .o_pix_en (pix_en_s)
  );

  // A strobe only moves the raster while the generator is enabled
  assign advance_s = pix_en_s & i_enable;

  // Next raster position: h wraps at the end of a line and carries into v
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (advance_s) begin
      if (h_cnt_r == H_LAST) begin
        h_nxt_s = '0;
        if (v_cnt_r == V_LAST) begin
          v_nxt_s = '0;
        end else begin
          v_nxt_s = v_cnt_r + CNT_W'(1);
        end
      end else begin
        h_nxt_s = h_cnt_r + CNT_W'(1);
        v_nxt_s = v_cnt_r;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Decode of the next position; strobes fire only on the edge that moves to col 0
  always_comb begin
    active_nxt_s = in_window(32'(h_nxt_s), 32'd0, 32'(H_ACTIVE - 1)) &&
                   in_window(32'(v_nxt_s), 32'd0, 32'(V_ACTIVE - 1));
    hsync_nxt_s  = sync_level(in_window(32'(h_nxt_s), 32'(HS_LO), 32'(HS_HI)), SYNC_POL);
    vsync_nxt_s  = sync_level(in_window(32'(v_nxt_s), 32'(VS_LO), 32'(VS_HI)), SYNC_POL);
    line_start_nxt_s  = advance_s && (h_nxt_s == '0);
    frame_start_nxt_s = advance_s && (h_nxt_s == '0) && (v_nxt_s == '0);
  end

  // Counters and output registers; a held position yields held outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_r       <= H_LAST;
      v_cnt_r       <= V_LAST;
      active_r      <= 1'b0;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      h_cnt_r       <= h_nxt_s;
      v_cnt_r       <= v_nxt_s;
      active_r      <= active_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      line_start_r  <= line_start_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign o_pix_en      = pix_en_s;
  assign o_hsync       = hsync_r;
  assign o_vsync       = vsync_r;
  assign o_active      = active_r;
  assign o_col         = h_cnt_r;
  assign o_row         = v_cnt_r;
  assign o_line_start  = line_start_r;
  assign o_frame_start = frame_start_r;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that sits directly upstream of the VGA test-pattern top-level.
- Divides i_clk into a pixel-enable strobe.
- Runs horizontal and vertical counters over the full raster.
- Produces hsync/vsync, an active-video flag, pixel coordinates, and line/frame start strobes.
- The pattern generator consumes these to choose RGB; the syncs pass through to the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 1, i_clk cycles per pixel (>=1)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- CNT_W, 10, coordinate counter width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  run (1) / freeze (0)
- o_pix_en  out  1  one-cycle pixel strobe
- o_hsync  out  1  horizontal sync, level per SYNC_POL
- o_vsync  out  1  vertical sync, level per SYNC_POL
- o_active  out  1  current pixel is inside the visible area
- o_col  out  CNT_W  current h count
- o_row  out  CNT_W  current v count
- o_line_start  out  1  one-cycle pulse at col 0
- o_frame_start  out  1  one-cycle pulse at (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration error if H_TOTAL or V_TOTAL > 2^CNT_W, or CLK_DIV < 1.
- Reset (async, immediate, no clock needed):
  - div_cnt = 0
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so o_col = 799 and o_row = 524
  - o_pix_en = 0, o_active = 0, o_line_start = 0, o_frame_start = 0
  - o_hsync = o_vsync = ~SYNC_POL (deasserted)
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 while i_enable = 1.
  - o_pix_en is registered: it is 1 in the cycle after div_cnt == CLK_DIV-1 with i_enable = 1.
  - CLK_DIV = 1: o_pix_en is high continuously from the first edge after reset release (given i_enable = 1).
- Counter advance: on each rising edge where o_pix_en = 1:
  - h_cnt <= (h_cnt == H_TOTAL-1) ? 0 : h_cnt+1
  - on h wrap, v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1
  - otherwise v_cnt holds.
- Output registers update on the same edge from the next counter values, so every output is consistent with o_col/o_row. Outputs hold between strobes.
  - o_active = (col < H_ACTIVE) && (row < V_ACTIVE)
  - o_hsync = SYNC_POL when col is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); else ~SYNC_POL
  - o_vsync = SYNC_POL when row is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for the whole line including h blanking; else ~SYNC_POL
  - o_line_start = 1 for exactly one i_clk cycle after the edge that loads col = 0
  - o_frame_start = 1 for exactly one i_clk cycle after the edge that loads (0,0); o_line_start is also 1 in that cycle
- First-pixel latency (CLK_DIV = 1, i_enable = 1 at release):
  - edge 1: o_pix_en = 1
  - edge 2: counters at (0,0), o_frame_start = 1, o_active = 1
- i_enable = 0:
  - prescaler and counters freeze; o_pix_en = 0 from the next edge
  - o_line_start/o_frame_start clear; all other outputs hold
  - re-enable resumes from the frozen position; no frame restart
- Reset mid-frame: all state returns to reset values asynchronously; the next frame starts cleanly at (0,0) after release.
- Simultaneous h and v wrap (799,524 -> 0,0): single transition; both strobes fire in the same cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL)
  - the SYNC_POL encoding
  - CNT_W
- One sub-module is natural: vga_pix_en_div, the CLK_DIV prescaler with i_enable gating, producing the registered o_pix_en.
- Counter and decode logic stays in vga_timing_gen.

Test Plan:
1. Reset release, CLK_DIV = 1, i_enable = 1 -> o_pix_en = 1 at edge 1; at edge 2 o_col = 0, o_row = 0, o_active = 1, o_frame_start = o_line_start = 1 for one cycle.
2. Run 3 lines -> o_hsync low exactly for col 656..751 (96 strobes) each line; o_line_start every 800 strobes; o_active low for col 640..799.
3. Run 2 frames -> o_vsync low for exactly rows 490..491 (1600 strobes); o_frame_start spacing = 420000 strobes; o_active high count = 307200 per frame.
4. CLK_DIV = 4 -> o_pix_en high 1 of every 4 cycles; o_col steps once per strobe; drop i_enable for 10 cycles at col 100 -> o_col stays 100, o_pix_en = 0; resumes at 101.
5. Assert i_rst at row 200, col 300 between clock edges -> o_col = 799, o_row = 524, o_active = 0, syncs = 1 immediately without a clock edge; after release, the frame restarts at (0,0).
6. SYNC_POL = 1 -> o_hsync/o_vsync high only in the sync windows, low at reset and elsewhere.
